// File: rtl/alu_ctl_pkg.sv
// rtl/alu_ctl_pkg.sv - shared constants and types for alu_control_pipe
package alu_ctl_pkg;

    // ALU operation codes (low 4 bits of ALUCtr)
    localparam logic [3:0] CTR_ADD  = 4'd0;
    localparam logic [3:0] CTR_SUB  = 4'd1;
    localparam logic [3:0] CTR_AND  = 4'd2;
    localparam logic [3:0] CTR_OR   = 4'd3;
    localparam logic [3:0] CTR_SLL  = 4'd4;
    localparam logic [3:0] CTR_LUI  = 4'd5;
    localparam logic [3:0] CTR_XOR  = 4'd6;
    localparam logic [3:0] CTR_SLT  = 4'd7;
    localparam logic [3:0] CTR_SLTU = 4'd8;
    localparam logic [3:0] CTR_NOR  = 4'd9;
    localparam logic [3:0] CTR_SRL  = 4'd10;
    localparam logic [3:0] CTR_SRA  = 4'd11;
    localparam logic [3:0] CTR_PASS = 4'd12;

    // R-type function fields
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    // Main-control op classes; bit 3 set means R-type
    localparam logic [3:0] OP_LS   = 4'b0000;
    localparam logic [3:0] OP_BR   = 4'b0001;
    localparam logic [3:0] OP_ANDI = 4'b0010;
    localparam logic [3:0] OP_ORI  = 4'b0011;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_LUI  = 4'b0101;
    localparam logic [3:0] OP_XORI = 4'b0110;
    localparam logic [3:0] OP_SLTI = 4'b0111;
    localparam logic [3:0] OP_RTYPE = 4'b1000;

    // Multiply/divide operation encodings
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_t;

endpackage

// File: rtl/alu_control_pipe_if.sv
// rtl/alu_control_pipe_if.sv - decode-side bundle for alu_control_pipe
interface alu_control_pipe_if #(
    parameter int CTR_W = 4
);
    logic             valid_in;
    logic [3:0]       ALUOp;
    logic [5:0]       func;
    logic             stall;
    logic             flush;
    logic             stall_req;
    logic             valid_out;
    logic             ALUSrcA;
    logic             ALUSrcB;
    logic [CTR_W-1:0] ALUCtr;
    logic             illegal_op;
    logic             md_start;
    logic [1:0]       md_op;
    logic             md_busy;
    logic             md_done;

    modport master (
        output valid_in, ALUOp, func, stall, flush,
        input  stall_req, valid_out, ALUSrcA, ALUSrcB, ALUCtr, illegal_op,
               md_start, md_op, md_busy, md_done
    );

    modport slave (
        input  valid_in, ALUOp, func, stall, flush,
        output stall_req, valid_out, ALUSrcA, ALUSrcB, ALUCtr, illegal_op,
               md_start, md_op, md_busy, md_done
    );
endinterface

// File: rtl/md_seq.sv
// rtl/md_seq.sv - multiply/divide busy counter and sequencer FSM
module md_seq
    import alu_ctl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic done
);
    md_state_t        state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    // State and counter registers; only reset can abort a running sequence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next state: load the latency on start, count down to zero, then idle
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            MD_IDLE: begin
                if (start) begin
                    state_nx = MD_RUN;
                    cnt_nx   = is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
                end
            end
            MD_RUN: begin
                if (cnt == '0) begin
                    state_nx = MD_IDLE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: state_nx = MD_IDLE;
        endcase
    end

    assign busy = (state == MD_RUN);
    assign done = busy && (cnt == '0);

endmodule

// File: rtl/alu_control_pipe.sv
// rtl/alu_control_pipe.sv - registered ALU-control decoder with MULT/DIV sequencer; ALUCTL_DIV_EN enables DIV/DIVU
module alu_control_pipe
    import alu_ctl_pkg::*;
#(
    parameter int CTR_W      = 4,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_control_pipe_if.slave bus
);
    logic [3:0] dec_ctr;
    logic       dec_a;
    logic       dec_b;
    logic       dec_ill;
    logic       dec_md;
    logic       dec_mf;
    logic [1:0] dec_op;
    logic       accept;
    logic       seq_start;

    // Decode ALUOp/func into operand selects, ALU code and MD classification
    always_comb begin
        dec_ctr = CTR_ADD;
        dec_a   = 1'b0;
        dec_b   = 1'b0;
        dec_ill = 1'b0;
        dec_md  = 1'b0;
        dec_mf  = 1'b0;
        dec_op  = MD_MULT;
        if (bus.ALUOp[3]) begin
            case (bus.func)
                F_ADD, F_ADDU: dec_ctr = CTR_ADD;
                F_SUB, F_SUBU: dec_ctr = CTR_SUB;
                F_AND:         dec_ctr = CTR_AND;
                F_OR:          dec_ctr = CTR_OR;
                F_XOR:         dec_ctr = CTR_XOR;
                F_NOR:         dec_ctr = CTR_NOR;
                F_SLT:         dec_ctr = CTR_SLT;
                F_SLTU:        dec_ctr = CTR_SLTU;
                F_SLL:   begin dec_ctr = CTR_SLL; dec_a = 1'b1; end
                F_SRL:   begin dec_ctr = CTR_SRL; dec_a = 1'b1; end
                F_SRA:   begin dec_ctr = CTR_SRA; dec_a = 1'b1; end
                F_MFHI, F_MFLO: begin dec_ctr = CTR_PASS; dec_mf = 1'b1; end
                F_MULT:  begin dec_ctr = CTR_PASS; dec_md = 1'b1; dec_op = MD_MULT;  end
                F_MULTU: begin dec_ctr = CTR_PASS; dec_md = 1'b1; dec_op = MD_MULTU; end
`ifdef ALUCTL_DIV_EN
                F_DIV:   begin dec_ctr = CTR_PASS; dec_md = 1'b1; dec_op = MD_DIV;   end
                F_DIVU:  begin dec_ctr = CTR_PASS; dec_md = 1'b1; dec_op = MD_DIVU;  end
`endif
                default: dec_ill = 1'b1;
            endcase
        end else begin
            dec_b = 1'b1;
            case (bus.ALUOp)
                OP_BR:   begin dec_ctr = CTR_SUB; dec_b = 1'b0; end
                OP_ANDI: dec_ctr = CTR_AND;
                OP_ORI:  dec_ctr = CTR_OR;
                OP_LUI:  dec_ctr = CTR_LUI;
                OP_XORI: dec_ctr = CTR_XOR;
                OP_SLTI: dec_ctr = CTR_SLT;
                OP_LS, OP_ADDI: dec_ctr = CTR_ADD;
                default: dec_ctr = CTR_ADD;
            endcase
        end
    end

    // HI/LO hazard: an MD op or MFHI/MFLO must wait while a sequence is live
    assign bus.stall_req = bus.valid_in && (dec_md || dec_mf) && (bus.md_busy || bus.md_start);
    assign accept        = bus.valid_in && !bus.stall && !bus.stall_req && !bus.flush;
    assign seq_start     = accept && dec_md;

    // EX-stage control register: flush beats stall, stall holds everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.valid_out  <= 1'b0;
            bus.ALUSrcA    <= 1'b0;
            bus.ALUSrcB    <= 1'b0;
            bus.ALUCtr     <= '0;
            bus.illegal_op <= 1'b0;
            bus.md_start   <= 1'b0;
            bus.md_op      <= MD_MULT;
        end else if (bus.flush) begin
            bus.valid_out  <= 1'b0;
            bus.ALUSrcA    <= 1'b0;
            bus.ALUSrcB    <= 1'b0;
            bus.ALUCtr     <= '0;
            bus.illegal_op <= 1'b0;
            bus.md_start   <= 1'b0;
            bus.md_op      <= MD_MULT;
        end else if (!bus.stall) begin
            bus.valid_out  <= bus.valid_in && !bus.stall_req;
            bus.ALUSrcA    <= dec_a;
            bus.ALUSrcB    <= dec_b;
            bus.ALUCtr     <= CTR_W'(dec_ctr);
            bus.illegal_op <= dec_ill;
            bus.md_start   <= seq_start;
            bus.md_op      <= dec_op;
        end
    end

    md_seq #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_md_seq (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (seq_start),
        .is_div (dec_op[1]),
        .busy   (bus.md_busy),
        .done   (bus.md_done)
    );

endmodule

// File: tb/tb_alu_control_pipe.sv
// tb/tb_alu_control_pipe.sv - scoreboard bench for alu_control_pipe
module tb_alu_control_pipe;
    import alu_ctl_pkg::*;

    localparam int MUL_N = 4;
`ifdef ALUCTL_DIV_EN
    localparam int         SEQ_LEN  = 32;
    localparam logic [5:0] SEQ_FN   = 6'b011010;
    localparam logic [1:0] SEQ_OP   = 2'b10;
    localparam int         RST_WAIT = 11;
`else
    localparam int         SEQ_LEN  = 4;
    localparam logic [5:0] SEQ_FN   = 6'b011001;
    localparam logic [1:0] SEQ_OP   = 2'b01;
    localparam int         RST_WAIT = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_control_pipe_if #(.CTR_W(4)) bus();

    alu_control_pipe #(
        .CTR_W(4), .MUL_CYCLES(MUL_N), .DIV_CYCLES(32), .CNT_W(6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic       v;
        logic       a;
        logic       b;
        logic [3:0] ctr;
        logic       ill;
        logic       st;
        logic [1:0] op;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic v, input logic a, input logic b, input logic [3:0] ctr,
                                input logic ill, input logic st, input logic [1:0] op);
        exp_t e;
        e.v = v; e.a = a; e.b = b; e.ctr = ctr; e.ill = ill; e.st = st; e.op = op;
        return e;
    endfunction

    task automatic drive(input logic [3:0] op, input logic [5:0] fn, input exp_t e);
        bus.valid_in = 1'b1;
        bus.ALUOp    = op;
        bus.func     = fn;
        sb.push_back(e);
    endtask

    task automatic collect(input string tag);
        exp_t e;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        check({tag, "_sbsz"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_valid"}, bus.valid_out, e.v);
            check({tag, "_srca"},  bus.ALUSrcA, e.a);
            check({tag, "_srcb"},  bus.ALUSrcB, e.b);
            check({tag, "_ctr"},   bus.ALUCtr, e.ctr);
            check({tag, "_ill"},   bus.illegal_op, e.ill);
            check({tag, "_start"}, bus.md_start, e.st);
            check({tag, "_mdop"},  bus.md_op, e.op);
        end
    endtask

    task automatic issue(input string tag, input logic [3:0] op, input logic [5:0] fn, input exp_t e);
        drive(op, fn, e);
        collect(tag);
    endtask

    task automatic zeros(input string tag);
        check({tag, "_valid"}, bus.valid_out, 0);
        check({tag, "_srca"},  bus.ALUSrcA, 0);
        check({tag, "_srcb"},  bus.ALUSrcB, 0);
        check({tag, "_ctr"},   bus.ALUCtr, 0);
        check({tag, "_ill"},   bus.illegal_op, 0);
        check({tag, "_start"}, bus.md_start, 0);
        check({tag, "_mdop"},  bus.md_op, 0);
        check({tag, "_busy"},  bus.md_busy, 0);
        check({tag, "_done"},  bus.md_done, 0);
    endtask

    initial begin
        int done_cnt;
        bus.valid_in = 1'b0;
        bus.ALUOp    = 4'b0;
        bus.func     = 6'b0;
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        zeros("rst");
        check("rst_sreq", bus.stall_req, 0);
        rst_n = 1'b1;

        // R-type and I-type decode
        issue("sub",  OP_RTYPE, 6'b100010, mk(1, 0, 0, 4'd1,  0, 0, 2'b00));
        issue("sra",  OP_RTYPE, 6'b000011, mk(1, 1, 0, 4'd11, 0, 0, 2'b00));
        issue("sll",  OP_RTYPE, 6'b000000, mk(1, 1, 0, 4'd4,  0, 0, 2'b00));
        issue("nor",  OP_RTYPE, 6'b100111, mk(1, 0, 0, 4'd9,  0, 0, 2'b00));
        issue("sltu", OP_RTYPE, 6'b101011, mk(1, 0, 0, 4'd8,  0, 0, 2'b00));
        issue("beq",  4'b0001,  6'b111111, mk(1, 0, 0, 4'd1,  0, 0, 2'b00));
        issue("lui",  4'b0101,  6'b000000, mk(1, 0, 1, 4'd5,  0, 0, 2'b00));
        issue("slti", 4'b0111,  6'b000000, mk(1, 0, 1, 4'd7,  0, 0, 2'b00));
        issue("addi", 4'b0100,  6'b000000, mk(1, 0, 1, 4'd0,  0, 0, 2'b00));

        // MULT, then MFLO held off by the hazard until busy drops
        issue("mult", OP_RTYPE, 6'b011000, mk(1, 0, 0, 4'd12, 0, 1, 2'b00));
        drive(OP_RTYPE, 6'b010010, mk(1, 0, 0, 4'd12, 0, 0, 2'b00));
        for (int i = 0; i < MUL_N; i++) begin
            #1;
            check("mul_sreq", bus.stall_req, 1);
            check("mul_busy", bus.md_busy, 1);
            check("mul_done", bus.md_done, (i == MUL_N - 1));
            if (i > 0) begin
                check("mul_start_clr", bus.md_start, 0);
                check("mul_vout", bus.valid_out, 0);
            end
            @(posedge clk); #1;
        end
        check("mul_busy_end", bus.md_busy, 0);
        check("mul_sreq_end", bus.stall_req, 0);
        collect("mflo");

        // flush wins over stall
        bus.stall = 1'b1; bus.flush = 1'b1;
        bus.valid_in = 1'b1; bus.ALUOp = OP_ORI; bus.func = 6'b0;
        @(posedge clk); #1;
        check("sf_valid", bus.valid_out, 0);
        check("sf_ctr", bus.ALUCtr, 0);
        check("sf_srcb", bus.ALUSrcB, 0);
        bus.stall = 1'b0; bus.flush = 1'b0;
        issue("ori", OP_ORI, 6'b0, mk(1, 0, 1, 4'd3, 0, 0, 2'b00));

        // stall alone holds the register
        bus.stall = 1'b1;
        bus.valid_in = 1'b1; bus.ALUOp = OP_RTYPE; bus.func = 6'b100010;
        repeat (3) begin
            @(posedge clk); #1;
            check("hold_valid", bus.valid_out, 1);
            check("hold_ctr", bus.ALUCtr, 3);
            check("hold_srcb", bus.ALUSrcB, 1);
        end
        bus.stall = 1'b0; bus.valid_in = 1'b0;

        // Illegal ops
        issue("ill", OP_RTYPE, 6'b111111, mk(1, 0, 0, 4'd0, 1, 0, 2'b00));
        check("ill_busy", bus.md_busy, 0);
`ifndef ALUCTL_DIV_EN
        issue("div_off", OP_RTYPE, 6'b011010, mk(1, 0, 0, 4'd0, 1, 0, 2'b00));
        repeat (3) begin
            check("div_off_busy", bus.md_busy, 0);
            @(posedge clk); #1;
        end
`endif

        // Sequence survives a flush and pulses done exactly once
        issue("seq", OP_RTYPE, SEQ_FN, mk(1, 0, 0, 4'd12, 0, 1, SEQ_OP));
        bus.flush = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            #1;
            check("seq_busy", bus.md_busy, 1);
            check("seq_done", bus.md_done, (i == SEQ_LEN - 1));
            if (bus.md_done) done_cnt++;
            if (i > 0) check("seq_flushed", bus.valid_out, 0);
            @(posedge clk); #1;
            bus.flush = 1'b0;
        end
        check("seq_busy_end", bus.md_busy, 0);
        check("seq_done_cnt", done_cnt, 1);

        // Async reset in the middle of a sequence
        issue("rseq", OP_RTYPE, SEQ_FN, mk(1, 0, 0, 4'd12, 0, 1, SEQ_OP));
        repeat (RST_WAIT) @(posedge clk);
        #1;
        check("rseq_busy_pre", bus.md_busy, 1);
        rst_n = 1'b0;
        #1;
        zeros("rmid");
        rst_n = 1'b1;
        issue("add_after", OP_RTYPE, 6'b100000, mk(1, 0, 0, 4'd0, 0, 0, 2'b00));
        check("add_after_busy", bus.md_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_control_pipe.md
Name: alu_control_pipe

Overview:
Registered, parametrised ALU-control decoder for the pipelined CPU. It sits at the ID/EX boundary and turns ALUOp/func into operand-select and a widened ALU operation code. It adds a multi-cycle sequencer for MULT/DIV and raises a stall request on HI/LO hazards. It handles pipeline stall/flush and flags undecodable ops.

Parameters:
CTR_W, 4, width of ALUCtr (≥4; codes below occupy the low 4 bits, upper bits zero)
MUL_CYCLES, 4, busy cycles for MULT/MULTU (≥1)
DIV_CYCLES, 32, busy cycles for DIV/DIVU (≥1)
CNT_W, 6, busy-counter width; must satisfy 2^CNT_W > max(MUL_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
valid_in  in  1  decode-stage instruction valid
ALUOp  in  4  main-control ALU op class
func  in  6  R-type function field
stall  in  1  downstream hold; freeze output register
flush  in  1  kill decode-stage instruction
stall_req  out  1  combinational; hold upstream (HI/LO hazard)
valid_out  out  1  registered instruction valid (EX stage)
ALUSrcA  out  1  registered; 1 = shamt operand
ALUSrcB  out  1  registered; 1 = immediate operand
ALUCtr  out  CTR_W  registered ALU operation
illegal_op  out  1  registered; unsupported func/ALUOp
md_start  out  1  one-cycle pulse, aligned with valid_out
md_op  out  2  registered; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
md_busy  out  1  multiply/divide in progress
md_done  out  1  one-cycle pulse on the final busy cycle

Behaviour:
- Reset (async, rst_n=0): valid_out, ALUSrcA, ALUSrcB, ALUCtr, illegal_op, md_start, md_op, md_busy, md_done, counter all 0; FSM=IDLE.
- ALUCtr codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 LUI, 6 XOR, 7 SLT, 8 SLTU, 9 NOR, 10 SRL, 11 SRA, 12 PASS.
- ALUOp[3]=1, R-type func mapping:
  - 100000/100001 → 0
  - 100010/100011 → 1
  - 100100 → 2; 100101 → 3; 100110 → 6; 100111 → 9
  - 101010 → 7; 101011 → 8
  - 000000 → 4; 000010 → 10; 000011 → 11; shifts set ALUSrcA=1
  - 010000/010010 (MFHI/MFLO) → 12
  - 011000..011011 → MD op, ALUCtr=12
  - any other func → illegal_op=1, ALUCtr=0
  - ALUSrcB=0 for all R-type.
- ALUOp[3]=0 mapping: ALUSrcB=1 except ALUOp=0001 (branch, SUB, ALUSrcB=0).
  - 0010 → 2; 0011 → 3; 0101 → 5; 0110 → 6; 0111 → 7
  - 0000 and 0100 → 0
  - codes 0001–0111 not listed above → 0; ALUOp[3]=0 never raises illegal_op.
- Latency: one cycle from accept to registered outputs.
- Accept = valid_in & ~stall & ~stall_req & ~flush.
- Register update priority:
  - flush: load NOP (valid_out=0, all controls 0), even when stall=1
  - else stall: hold all registered outputs
  - else: load decode; valid_out = valid_in & ~stall_req
- stall_req = valid_in & md_busy & (instruction is MD op or MFHI/MFLO); also high during the md_start cycle for such ops.
- md_start is cleared the cycle after it pulses unless stall holds it; it is never re-issued while held.
- Sequencer states and transitions:
  - IDLE → RUN on accepted MD op: md_start=1, md_busy=1, counter = MUL_CYCLES-1 or DIV_CYCLES-1.
  - RUN: counter decrements each cycle. At counter=0: md_done=1, then → IDLE with md_busy=0 next cycle.
  - A latency of 1 gives md_done in the same cycle as md_start.
- flush and stall never abort a sequence already in RUN; only rst_n does.
- Illegal op: decoded as NOP with valid_out=1; never starts the sequencer.

Optional Feature:
ALUCTL_DIV_EN
- Defined: DIV/DIVU decode as above.
- Undefined: func 011010/011011 → illegal_op=1, no md_start, DIV_CYCLES unused; MULT/MULTU unaffected.

Decomposition:
- Package alu_ctl_pkg holds:
  - ALUCtr code constants (ADD..PASS)
  - func constants
  - ALUOp constants
  - md_op encodings
  - FSM state constants (IDLE, RUN)
- Sub-module md_seq: the busy counter/FSM. Inputs clk, rst_n, start, is_div; outputs busy, done.

Test Plan:
1. Reset mid-RUN (DIV, counter=20) → all outputs 0 next sample, FSM IDLE; a following ADD decodes normally.
2. R-type func=100010, valid_in=1 → next cycle valid_out=1, ALUCtr=1, ALUSrcA=0, ALUSrcB=0; func=000011 → ALUCtr=11, ALUSrcA=1.
3. MULT accepted → md_start=1 one cycle, md_busy=1 for 4 cycles, md_done on 4th; MFLO issued during busy → stall_req=1 until busy drops, then accepted with ALUCtr=12.
4. stall=1 and flush=1 together with valid ORI → valid_out=0, ALUCtr=0; stall-only → outputs held unchanged for 3 cycles.
5. func=111111 → illegal_op=1, valid_out=1, ALUCtr=0, md_start=0; with ALUCTL_DIV_EN undefined, func=011010 → illegal_op=1, md_busy stays 0.
6. DIV, then flush while md_busy → md_busy stays 1 for the full 32 cycles, md_done pulses once.
